// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate-kind enum and skid-buffer entry layout
// for the ID-stage immediate issue buffer.
package imm_pkg;

    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_SIGN  = 2'd1,
        KIND_ZERO  = 2'd2,
        KIND_UPPER = 2'd3
    } imm_kind_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] br_off;
        logic        use_imm;
        imm_kind_e   kind;
    } imm_entry_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/imm_ext_unit.sv
// Combinational opcode decode and 16-bit immediate extension.
// Macro LUI_UPPER_EN: LUI is extended as UPPER here instead of ZERO (shift left to EX).
module imm_ext_unit
    import imm_pkg::*;
(
    input  logic [31:0] instr,
    output imm_entry_t  entry
);

    logic [5:0]  opcode;
    logic [15:0] imm16;
    logic        unused_fields;

    assign opcode        = instr[31:26];
    assign imm16         = instr[15:0];
    assign unused_fields = ^instr[25:16];

    always_comb begin
        entry = '0;
        case (opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                entry.kind    = KIND_SIGN;
                entry.imm     = sign_ext16(imm16);
                entry.use_imm = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                entry.kind    = KIND_SIGN;
                entry.imm     = sign_ext16(imm16);
                entry.use_imm = 1'b0;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                entry.kind    = KIND_ZERO;
                entry.imm     = {16'h0000, imm16};
                entry.use_imm = 1'b1;
            end
            OP_LUI: begin
`ifdef LUI_UPPER_EN
                entry.kind    = KIND_UPPER;
                entry.imm     = {imm16, 16'h0000};
`else
                entry.kind    = KIND_ZERO;
                entry.imm     = {16'h0000, imm16};
`endif
                entry.use_imm = 1'b1;
            end
            default: ;
        endcase
        // Branch offset is produced for every recognised opcode so EX never re-decodes.
        if (entry.kind != KIND_NONE) begin
            entry.br_off = {{14{imm16[15]}}, imm16, 2'b00};
        end
    end

endmodule

// File: rtl/imm_issue_buf.sv
// Immediate decode feeding a 2-entry valid/ready skid buffer at the ID/EX boundary.
// Macro LUI_UPPER_EN (see imm_ext_unit) selects UPPER extension for LUI.
module imm_issue_buf
    import imm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [31:0] out_br_off,
    output logic        out_use_imm,
    output logic [1:0]  out_kind
);

    buf_state_e state;
    imm_entry_t head;
    imm_entry_t tail;
    imm_entry_t new_entry;
    logic       accept;
    logic       drain;

    imm_ext_unit u_ext (
        .instr (instr),
        .entry (new_entry)
    );

    assign in_ready  = (state != BUF_FULL);
    assign out_valid = (state != BUF_EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // Slots are zeroed whenever they go invalid so an empty head reads as all-zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BUF_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            state <= BUF_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        head  <= new_entry;
                        state <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && drain) begin
                        head <= new_entry;
                    end else if (accept) begin
                        tail  <= new_entry;
                        state <= BUF_FULL;
                    end else if (drain) begin
                        head  <= '0;
                        state <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (drain) begin
                        head  <= tail;
                        tail  <= '0;
                        state <= BUF_ONE;
                    end
                end
                default: begin
                    state <= BUF_EMPTY;
                    head  <= '0;
                    tail  <= '0;
                end
            endcase
        end
    end

    assign out_imm     = head.imm;
    assign out_br_off  = head.br_off;
    assign out_use_imm = head.use_imm;
    assign out_kind    = head.kind;

endmodule

// File: tb/tb_imm_issue_buf.sv
// Directed self-checking bench for imm_issue_buf (honours LUI_UPPER_EN if defined).
module tb_imm_issue_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_br_off;
    logic        out_use_imm;
    logic [1:0]  out_kind;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    imm_issue_buf dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_br_off  (out_br_off),
        .out_use_imm (out_use_imm),
        .out_kind    (out_kind)
    );

    function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'h155, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic v, input logic [31:0] imm,
                            input logic [31:0] br, input logic use_imm, input logic [1:0] kind,
                            input logic rdy);
        checkOutput({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        checkOutput({tag, ".imm"}, out_imm, imm);
        checkOutput({tag, ".br_off"}, out_br_off, br);
        checkOutput({tag, ".use_imm"}, {31'd0, out_use_imm}, {31'd0, use_imm});
        checkOutput({tag, ".kind"}, {30'd0, out_kind}, {30'd0, kind});
        checkOutput({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
    endtask

    // Drive one cycle of inputs, then leave the bench 1 time unit after the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic ordy,
                                 input logic fl);
        in_valid  = v;
        instr     = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        #1;
        checkAll("reset", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(1'b1, mkInstr(6'h08, 16'hFFF0), 1'b1, 1'b0);
        checkAll("addi", 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFC0, 1'b1, 2'd1, 1'b1);

        // Accept and drain together while holding one entry.
        applyStimulus(1'b1, mkInstr(6'h0D, 16'h8001), 1'b1, 1'b0);
        checkAll("ori", 1'b1, 32'h0000_8001, 32'hFFFE_0004, 1'b1, 2'd2, 1'b1);

        applyStimulus(1'b1, mkInstr(6'h0F, 16'h1234), 1'b1, 1'b0);
`ifdef LUI_UPPER_EN
        checkAll("lui", 1'b1, 32'h1234_0000, 32'h0000_48D0, 1'b1, 2'd3, 1'b1);
`else
        checkAll("lui", 1'b1, 32'h0000_1234, 32'h0000_48D0, 1'b1, 2'd2, 1'b1);
`endif

        applyStimulus(1'b1, mkInstr(6'h04, 16'h0010), 1'b1, 1'b0);
        checkAll("beq", 1'b1, 32'h0000_0010, 32'h0000_0040, 1'b0, 2'd1, 1'b1);

        applyStimulus(1'b1, mkInstr(6'h00, 16'h1234), 1'b1, 1'b0);
        checkAll("rtype", 1'b1, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1);

        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkAll("drain_empty", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1);

        // Back-pressure: third ANDI must be refused.
        applyStimulus(1'b1, mkInstr(6'h0C, 16'h00F1), 1'b0, 1'b0);
        checkAll("bp1", 1'b1, 32'h0000_00F1, 32'h0000_03C4, 1'b1, 2'd2, 1'b1);
        applyStimulus(1'b1, mkInstr(6'h0C, 16'h00F2), 1'b0, 1'b0);
        checkAll("bp2", 1'b1, 32'h0000_00F1, 32'h0000_03C4, 1'b1, 2'd2, 1'b0);
        applyStimulus(1'b1, mkInstr(6'h0C, 16'h00F3), 1'b0, 1'b0);
        checkAll("bp3", 1'b1, 32'h0000_00F1, 32'h0000_03C4, 1'b1, 2'd2, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkAll("bp_drain1", 1'b1, 32'h0000_00F2, 32'h0000_03C8, 1'b1, 2'd2, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkAll("bp_drain2", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1);

        // Flush while FULL with a new instruction offered.
        applyStimulus(1'b1, mkInstr(6'h08, 16'h0001), 1'b0, 1'b0);
        applyStimulus(1'b1, mkInstr(6'h0E, 16'h0002), 1'b0, 1'b0);
        checkOutput("fl_full.in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b1, mkInstr(6'h2B, 16'h0003), 1'b1, 1'b1);
        checkAll("flush", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkAll("post_flush", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1);

        // Streaming throughput with out_ready held high.
        applyStimulus(1'b1, mkInstr(6'h0A, 16'h7FFF), 1'b1, 1'b0);
        checkAll("slti", 1'b1, 32'h0000_7FFF, 32'h0001_FFFC, 1'b1, 2'd1, 1'b1);
        applyStimulus(1'b1, mkInstr(6'h23, 16'hFFFF), 1'b1, 1'b0);
        checkAll("lw", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1, 2'd1, 1'b1);

        // Asynchronous reset while FULL.
        applyStimulus(1'b1, mkInstr(6'h2B, 16'h0004), 1'b0, 1'b0);
        checkOutput("rst_full.in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 checkAll("rst_mid", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1);
        #1 rst = 1'b0;
        applyStimulus(1'b1, mkInstr(6'h09, 16'h0005), 1'b1, 1'b0);
        checkAll("after_rst", 1'b1, 32'h0000_0005, 32'h0000_0014, 1'b1, 2'd1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkAll("final_empty", 1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/imm_issue_buf.md
# imm_issue_buf

Decodes the opcode of each ID-stage instruction, selects the immediate extension mode (sign / zero / upper), extends the 16-bit immediate, and delivers the result through a 2-entry valid/ready skid buffer into the ID/EX boundary. It owns all zero-extend vs sign-extend control for the pipeline, so the EX stage never decodes opcodes for immediate handling. Sits between instruction decode and the ID/EX register, with stall back-pressure from EX and a flush input from branch resolution.

## Interface
- Parameters: none.
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of all buffered and incoming entries.
- in_valid  in  1  ID offers an instruction this cycle.
- in_ready  out  1  buffer can accept; equals (count != 2).
- instr  in  32  instruction word; opcode = instr[31:26], imm16 = instr[15:0].
- out_valid  out  1  head entry valid.
- out_ready  in  1  EX consumes head this cycle.
- out_imm  out  32  extended immediate of head entry.
- out_br_off  out  32  sign-extended imm16 shifted left 2 (branch offset).
- out_use_imm  out  1  ALU B operand is out_imm.
- out_kind  out  2  0 NONE, 1 SIGN, 2 ZERO, 3 UPPER.

## Operation
- Decode (combinational, on instr):
  - SIGN, use_imm=1: ADDI 0x08, ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B, LW 0x23, SW 0x2B.
  - SIGN, use_imm=0: BEQ 0x04, BNE 0x05 (offset consumed via out_br_off).
  - ZERO, use_imm=1: ANDI 0x0C, ORI 0x0D, XORI 0x0E.
  - UPPER, use_imm=1: LUI 0x0F; imm = {imm16, 16'h0000}.
  - Any other opcode: NONE, imm=0, br_off=0, use_imm=0.
- SIGN: {16{imm16[15]}, imm16}. ZERO: {16'h0, imm16}. br_off always computed from sign extension regardless of kind, except NONE (0).
- Buffer: 2-entry FIFO of {imm, br_off, use_imm, kind}; states EMPTY (count 0), ONE (1), FULL (2).
- accept = in_valid & in_ready; drain = out_valid & out_ready.
- EMPTY: accept -> ONE. ONE: accept & !drain -> FULL; drain & !accept -> EMPTY; both -> ONE with new entry at head. FULL: drain -> ONE (second entry promoted to head); accept impossible.
- out_valid = (count != 0). Head fields output directly from registers; when EMPTY all out_* fields are 0.
- flush: next state EMPTY, all entry registers cleared, same-cycle accept and drain ignored. flush overrides everything except rst.
- Order preserved; no entry dropped or duplicated except by flush.

## Timing
- Reset (async, immediate): count=0, out_valid=0, out_imm=0, out_br_off=0, out_use_imm=0, out_kind=0; in_ready=1 once count=0.
- Latency: instruction accepted in cycle N appears at out_* in cycle N+1 if buffer was EMPTY, or after earlier entries drain.
- Throughput: one instruction per cycle while out_ready held high.
- in_ready depends only on registered count (no combinational path from out_ready to in_ready).
- Reset asserted mid-transfer: both entries lost, outputs zero same cycle; resume on first edge after deassertion.
- Flush in FULL with in_valid high: cycle after, count=0, out_valid=0, in_ready=1.

## Configuration
- LUI_UPPER_EN defined: LUI decodes as UPPER, out_imm = {imm16, 16'h0}.
- Not defined: LUI decodes as ZERO, out_imm = {16'h0, imm16}; EX performs the 16-bit shift. out_kind never takes value 3.

## Structure
- Package imm_pkg: opcode localparams listed above, imm kind enum (NONE/SIGN/ZERO/UPPER), FIFO entry struct.
- One sub-module imm_ext_unit: combinational decode and extension (instr -> entry fields); imm_issue_buf instantiates it once and holds the FIFO and state.

## Test plan
- ADDI imm16=0xFFF0, out_ready=1 -> next cycle out_imm=0xFFFFFFF0, out_kind=1, out_use_imm=1, out_br_off=0xFFFFFFC0.
- ORI imm16=0x8001 -> out_imm=0x00008001, out_kind=2; LUI imm16=0x1234 -> 0x12340000 kind 3 with LUI_UPPER_EN, 0x00001234 kind 2 without.
- out_ready=0, three back-to-back valid ANDI -> first two accepted, in_ready=0 in third cycle; then out_ready=1 -> both drain in order, in_ready returns 1.
- Count ONE with simultaneous accept and drain -> count stays ONE, head = new entry next cycle.
- FULL and flush=1 with in_valid=1 -> next cycle out_valid=0, all outputs 0, in_ready=1; flushed instruction never appears.
- Opcode 0x00 (R-type) -> out_kind=0, out_imm=0, out_use_imm=0; rst pulse while FULL -> outputs 0 immediately.
